// File: rtl/snn_cfg_pkg.sv
// ---------------------------------------------------------------------------
// snn_cfg_pkg
// Shared configuration for the spike window generator and the downstream
// MAC + NCHU neuron stage.
//   IMG_W / IMG_H : spike image geometry in pixels
//   K             : receptive-field edge; WIN_BITS = K*K window bits
//   MAC_WGT_BITS  : weight vector width used by the MAC (8 bits per tap)
// Also provides the counter / window typedefs and the window shift helper.
// ---------------------------------------------------------------------------
package snn_cfg_pkg;

  localparam int IMG_W        = 28;
  localparam int IMG_H        = 28;
  localparam int K            = 5;
  localparam int WIN_BITS     = K * K;
  localparam int MAC_WGT_BITS = WIN_BITS * 8;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef logic [COL_W-1:0]    col_t;
  typedef logic [ROW_W-1:0]    row_t;
  typedef logic [WIN_BITS-1:0] win_t;

  localparam col_t COL_LAST = col_t'(IMG_W - 1);
  localparam row_t ROW_LAST = row_t'(IMG_H - 1);
  // A window is complete once its bottom-right pixel sits at least K-1 rows
  // and K-1 columns into the frame.
  localparam col_t COL_GATE = col_t'(K - 1);
  localparam row_t ROW_GATE = row_t'(K - 1);

  // Shift the window one column to the left and insert a new rightmost
  // column. Window bit i*K+j holds row i (0 = oldest) and column j
  // (0 = leftmost); column[i] is the pixel for window row i.
  function automatic win_t win_shift(input win_t win, input logic [K-1:0] column);
    win_t res;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        res[i*K + j] = win[i*K + j + 1];
      end
      res[i*K + K - 1] = column[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/spike_line_buffer.sv
// ---------------------------------------------------------------------------
// spike_line_buffer
// Holds the K-1 most recent image lines, one K-1 bit word per column.
// Writing pixel din at column col pushes it into bit 0 of that column's word
// and moves the older lines one bit up, so the oldest line falls out.
// Ports:
//   clk    : system clock, rising edge
//   reset  : active-high reset; only blocks writes, contents are not cleared
//   wr_en  : write the accepted pixel this cycle
//   col    : column of the accepted pixel (read and write address)
//   din    : accepted pixel
//   dout   : older lines at column col; bit 0 = line r-1, bit K-2 = line r-(K-1)
// The read is combinational so the window column can be assembled in the
// same cycle the pixel is accepted (small LUT RAM, IMG_W x (K-1) bits).
// ---------------------------------------------------------------------------
module spike_line_buffer
  import snn_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [COL_W-1:0] col,
  input  logic             din,
  output logic [K-2:0]     dout
);

  logic [K-2:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[col] <= {mem[col][K-3:0], din};
    end
  end

  assign dout = mem[col];

endmodule

// File: rtl/spike_window_gen.sv
// ---------------------------------------------------------------------------
// spike_window_gen
// Turns a raster-scanned binary spike image into every valid KxK receptive
// field window, one window per accepted pixel once the window is complete.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   pix_in     : spike pixel (1 = spike)
//   pix_valid  : pix_in accepted this cycle
//   pix_sof    : start of frame, qualified by pix_valid; forces position (0,0)
//   pixels_out : registered window, bit i*K+j = image[r-(K-1)+i][c-(K-1)+j]
//   pulse      : one-cycle strobe, pixels_out updated this cycle
//   win_row    : row r of the window's bottom-right pixel
//   win_col    : column c of the window's bottom-right pixel
//   frame_done : high with pulse for the window ending at (IMG_H-1, IMG_W-1)
// Latency from accepted pixel to pulse is one cycle; no backpressure.
// ---------------------------------------------------------------------------
module spike_window_gen
  import snn_cfg_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_in,
  input  logic                pix_valid,
  input  logic                pix_sof,
  output logic [WIN_BITS-1:0] pixels_out,
  output logic                pulse,
  output logic [ROW_W-1:0]    win_row,
  output logic [COL_W-1:0]    win_col,
  output logic                frame_done
);

  col_t col_reg, col_next, cur_col;
  row_t row_reg, row_next, cur_row;
  win_t win_reg, win_next;

  logic [K-2:0] lb_dout;
  logic [K-1:0] column;
  logic         win_ready;

  // Position of the pixel on the input this cycle. A qualified start of
  // frame overrides whatever the counters hold.
  always_comb begin
    cur_col = col_reg;
    cur_row = row_reg;
    if (pix_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  // Raster advance from the current position; wraps into a free-running
  // next frame after the last pixel.
  always_comb begin
    col_next = cur_col + col_t'(1);
    row_next = cur_row;
    if (cur_col == COL_LAST) begin
      col_next = '0;
      row_next = (cur_row == ROW_LAST) ? '0 : cur_row + row_t'(1);
    end
  end

  // Windows straddling a line wrap fail the column test; windows reaching
  // into lines from before a start of frame fail the row test.
  assign win_ready = (cur_row >= ROW_GATE) && (cur_col >= COL_GATE);

  spike_line_buffer u_line_buffer (
    .clk   (clk),
    .reset (reset),
    .wr_en (pix_valid),
    .col   (cur_col),
    .din   (pix_in),
    .dout  (lb_dout)
  );

  // New rightmost window column, oldest line at window row 0.
  generate
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_column
      assign column[gi] = lb_dout[K-2-gi];
    end
  endgenerate
  assign column[K-1] = pix_in;

  assign win_next = win_shift(win_reg, column);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_reg    <= '0;
      row_reg    <= '0;
      win_reg    <= '0;
      pixels_out <= '0;
      pulse      <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      pulse      <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        col_reg <= col_next;
        row_reg <= row_next;
        win_reg <= win_next;
        if (win_ready) begin
          pixels_out <= win_next;
          win_row    <= cur_row;
          win_col    <= cur_col;
          pulse      <= 1'b1;
          frame_done <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_window_gen.sv
// ---------------------------------------------------------------------------
// tb_spike_window_gen
// Directed bench for spike_window_gen. Every accepted pixel and every idle
// cycle is checked against a reference image model; scenario-level checks
// cover pulse counts, first-pulse positions and frame_done.
// ---------------------------------------------------------------------------
module tb_spike_window_gen;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int KK = 5;
  localparam int NB = KK * KK;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_in = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic [NB-1:0] pixels_out;
  logic          pulse;
  logic [4:0]    win_row;
  logic [4:0]    win_col;
  logic          frame_done;

  always #5 clk = ~clk;

  spike_window_gen dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pixels_out (pixels_out),
    .pulse      (pulse),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit            img [H][W];
  bit            stream [2*NPIX];
  int            mr = 0, mc = 0;
  logic [NB-1:0] last_data = '0;
  logic [4:0]    last_row = '0, last_col = '0;
  int            pulse_cnt, done_cnt, first_pulse_beat;
  logic [34:0]   rec_q[$];
  logic [34:0]   ref_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] exp_win(input int r, input int c);
    logic [NB-1:0] w = '0;
    for (int i = 0; i < KK; i++)
      for (int j = 0; j < KK; j++)
        w[i*KK + j] = img[r-KK+1+i][c-KK+1+j];
    return w;
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0;
    last_data = '0; last_row = '0; last_col = '0;
  endtask

  task automatic clear_stats();
    pulse_cnt = 0; done_cnt = 0; first_pulse_beat = -1;
    rec_q.delete();
  endtask

  // One accepted pixel, checked one cycle later (sampled 1 time unit after the edge).
  task automatic send(input bit p, input bit sof);
    bit gate, done;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = p;
    gate = (mr >= KK-1) && (mc >= KK-1);
    done = gate && (mr == H-1) && (mc == W-1);
    if (gate) begin
      last_data = exp_win(mr, mc);
      last_row  = mr[4:0];
      last_col  = mc[4:0];
    end
    pix_in = p; pix_sof = sof; pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_in = 1'b0;
    chk("beat", {pulse, frame_done, win_row, win_col, pixels_out},
        {gate, done, last_row, last_col, last_data});
    if (pulse) begin
      pulse_cnt++;
      if (frame_done) done_cnt++;
      rec_q.push_back({win_row, win_col, pixels_out});
    end
    if (mc == W-1) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  // Idle cycle with random pix_in/pix_sof that must be ignored.
  task automatic idle();
    pix_valid = 1'b0;
    pix_in  = 1'($urandom_range(1));
    pix_sof = 1'($urandom_range(1));
    @(posedge clk); #1;
    pix_sof = 1'b0; pix_in = 1'b0;
    chk("idle", {pulse, frame_done, win_row, win_col, pixels_out},
        {2'b00, last_row, last_col, last_data});
  endtask

  task automatic feed(input int n, input int gap_pct, input int sof_at);
    for (int k = 0; k < n; k++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) idle();
      send(stream[k], k == sof_at);
      if (first_pulse_beat < 0 && pulse) first_pulse_beat = k;
    end
  endtask

  initial begin
    int mism;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pixels_out", pixels_out, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    model_reset();
    idle();

    // Single spike at (4,4)
    for (int k = 0; k < 2*NPIX; k++) stream[k] = 1'b0;
    stream[4*W + 4] = 1'b1;
    clear_stats();
    feed(NPIX, 0, 0);
    chk("spike_pulses", pulse_cnt, 576);
    chk("spike_first_beat", first_pulse_beat, 4*W + 4);
    chk("spike_first", rec_q[0], {5'd4, 5'd4, 25'h1000000});
    chk("spike_8_8", rec_q[100], {5'd8, 5'd8, 25'h0000001});
    chk("spike_done", done_cnt, 1);

    // All-ones frame
    for (int k = 0; k < 2*NPIX; k++) stream[k] = 1'b1;
    clear_stats();
    feed(NPIX, 0, 0);
    chk("ones_pulses", pulse_cnt, 576);
    chk("ones_done", done_cnt, 1);
    chk("ones_last", rec_q[575], {5'd27, 5'd27, 25'h1FFFFFF});

    // Random frame, back-to-back vs 30% idle
    for (int k = 0; k < 2*NPIX; k++) stream[k] = 1'($urandom_range(1));
    clear_stats();
    feed(NPIX, 0, 0);
    ref_q = rec_q;
    clear_stats();
    feed(NPIX, 30, 0);
    chk("gap_len", rec_q.size(), ref_q.size());
    mism = 0;
    for (int k = 0; k < ref_q.size() && k < rec_q.size(); k++)
      if (rec_q[k] !== ref_q[k]) mism++;
    chk("gap_seq", mism, 0);

    // pix_sof at pixel 100: ones before, random after
    for (int k = 0; k < 100; k++) stream[k] = 1'b1;
    clear_stats();
    feed(300, 0, 100);
    chk("sof_first_beat", first_pulse_beat, 100 + 116);
    chk("sof_first_pos", rec_q[0][34:25], {5'd4, 5'd4});

    // Asynchronous reset while pulse is high
    for (int k = 0; k < 2*NPIX; k++) stream[k] = 1'b1;
    clear_stats();
    feed(5*W + 10, 0, 0);
    chk("arst_pre_pulse", pulse, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_outputs", {pulse, frame_done, win_row, win_col, pixels_out}, 0);
    #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < 2*NPIX; k++) stream[k] = 1'($urandom_range(1));
    clear_stats();
    feed(150, 0, -1);
    chk("arst_first_beat", first_pulse_beat, 116);
    chk("arst_first_pos", rec_q[0][34:25], {5'd4, 5'd4});

    // Two consecutive frames without pix_sof
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    clear_stats();
    feed(2*NPIX, 0, -1);
    chk("two_pulses", pulse_cnt, 1152);
    chk("two_done", done_cnt, 2);
    chk("two_second_first", rec_q[576][34:25], {5'd4, 5'd4});
    chk("two_second_last", rec_q[1151][34:25], {5'd27, 5'd27});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spike_window_gen.md
Name: spike_window_gen

Overview:
- Upstream feeder for the MAC + NCHU neuron stage.
- Accepts a raster-scanned binary spike image, one pixel per accepted beat.
- Buffers K-1 full image lines and emits every valid KxK receptive-field window as a flat K*K-bit vector, with a one-cycle strobe.
- The window vector drives the neuron's pixel input and the strobe drives its pulse input.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 5, window edge; window width K*K = 25 bits

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- pix_in  input  1  current spike pixel (1 = spike)
- pix_valid  input  1  pix_in is accepted this cycle
- pix_sof  input  1  start of frame; qualified by pix_valid
- pixels_out  output  K*K  registered window; bit i*K+j = image[r-(K-1)+i][c-(K-1)+j]; bit 0 = top-left, bit K*K-1 = newest pixel
- pulse  output  1  one-cycle strobe: pixels_out updated this cycle
- win_row  output  $clog2(IMG_H)  row index r of the window's bottom-right pixel
- win_col  output  $clog2(IMG_W)  column index c of the window's bottom-right pixel
- frame_done  output  1  asserted together with pulse for the last window of the frame

Behaviour:
- Reset (async, active-high):
  - pixels_out, pulse, win_row, win_col and frame_done go to 0.
  - Column/row counters go to 0.
  - Line-buffer contents need not clear.
- Pixel acceptance:
  - Accept only when pix_valid=1. Cycles with pix_valid=0 change nothing; pulse=0.
  - Counters col (0..IMG_W-1) and row (0..IMG_H-1) address the accepted pixel.
  - After each accepted pixel, col increments. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0: a free-running next frame.
- Start of frame:
  - pix_sof=1 with pix_valid=1 forces the accepted pixel to position (0,0), regardless of counter state. Counters continue from (0,1).
  - pix_sof without pix_valid is ignored.
- Line buffer:
  - K-1 rows of IMG_W bits.
  - The accepted pixel at column c is written to row-0 slot c. Older rows shift down one line at that column.
  - Shift-register or RAM-with-pointer implementation permitted.
- Window register:
  - K x K bits. Each accept shifts left by one column.
  - The new rightmost column is {line buffer rows K-2..0 at column c, pix_in}.
- Output:
  - When the accepted pixel has r >= K-1 and c >= K-1, the next cycle has pulse=1, pixels_out = the window, win_row=r, win_col=c. Latency is 1 cycle.
  - Otherwise pulse=0 and pixels_out, win_row, win_col hold their values.
  - Windows whose columns straddle a line wrap are never emitted, because the c >= K-1 gate excludes them.
  - The r >= K-1 gate guarantees all window rows belong to the current frame, even after a mid-frame pix_sof.
- frame_done=1 exactly when pulse=1 and (r,c) = (IMG_H-1, IMG_W-1).
- Window count: each frame yields (IMG_H-K+1)*(IMG_W-K+1) pulses, i.e. 576 at defaults.
- Maximum rate is one pulse per cycle. There is no backpressure; the downstream neuron must accept every pulse.
- Reset asserted mid-frame aborts the frame. After release, the first accepted pixel is (0,0), with or without pix_sof.

Decomposition:
- Shared package snn_cfg_pkg:
  - Constants IMG_W, IMG_H, K, WIN_BITS = K*K.
  - Counter widths via $clog2.
  - The same K/WIN_BITS are used by the MAC weight width (WIN_BITS*8).
- One sub-module: spike_line_buffer.
  - Ports: clk, reset, wr_en, col, din.
  - Output: dout[K-2:0], the column of older rows.
- Counters, gating and window register stay in the top module.

Test Plan:
- Frame of all zeros except image[4][4]=1:
  - First pulse follows pixel (4,4) with pixels_out=25'h1000000 (bit 24).
  - The pulse for (8,8) shows 25'h0000001.
  - All other pulses whose window excludes (4,4) are 0.
- All-ones frame: exactly 576 pulses, each with pixels_out=25'h1FFFFFF. frame_done is high only on the final pulse, with win_row=27, win_col=27.
- Same random frame fed back-to-back vs with random pix_valid gaps (30% idle): identical pixels_out/win_row/win_col sequences; pulse never high in a cycle not following an accept.
- pix_sof asserted at pixel index 100 of a frame:
  - Counters restart.
  - First pulse occurs after the 117th pixel counted from the sof pixel, with win_row=4, win_col=4.
  - The window contains only post-sof pixels.
- Reset pulsed asynchronously mid-frame (between clock edges) while pulse=1: outputs drop to 0 immediately. The next 4*28+5=117 accepted pixels produce the first pulse, with win_row=4, win_col=4.
- Two consecutive frames without pix_sof: the second frame wraps at pixel 784 and produces another 576 pulses with correct indices.
